// File: rtl/cmd_arb_pkg.sv
// Shared types and helpers for the command-port round-robin arbiter.
package cmd_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RSP  = 2'd2,
    S_DLV  = 2'd3
  } arb_state_e;

  localparam int ARB_TIMEOUT = 256;
  localparam int CMD_W       = 32;
  localparam int MAX_REQ     = 8;
  localparam int BUS_W       = MAX_REQ * CMD_W;

  // Callers zero-extend their packed command bus to BUS_W before selecting.
  function automatic logic [CMD_W-1:0] cmd_slice(input logic [BUS_W-1:0] bus, input int idx);
    return CMD_W'(bus >> (CMD_W * idx));
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cmd_arb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module cmd_arb_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] next_idx
);

  int cand;

  // Scan from farthest to nearest so the nearest pending requester wins.
  always_comb begin
    valid    = 1'b0;
    next_idx = last;
    cand     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % N_REQ;
      if (req[cand[IDX_W-1:0]]) begin
        valid    = 1'b1;
        next_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cmd_arb.sv
// Round-robin arbiter sharing one processor cmd/rsp port among N_REQ sources.
module cmd_arb
  import cmd_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = ARB_TIMEOUT,
  parameter int IDX_W   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [32*N_REQ-1:0]    req_cmd_data,
  input  logic [N_REQ-1:0]       req_cmd_waitreq,
  output logic [N_REQ-1:0]       req_cmd_rdreq,
  output logic [31:0]            req_rsp_data,
  output logic [N_REQ-1:0]       req_rsp_wrreq,
  input  logic [N_REQ-1:0]       req_rsp_waitreq,
  output logic [31:0]            arb_cmd_data,
  output logic                   arb_cmd_waitreq,
  input  logic                   arb_cmd_rdreq,
  input  logic [31:0]            arb_rsp_data,
  input  logic                   arb_rsp_wrreq,
  output logic                   arb_rsp_waitreq,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   busy,
  output logic                   rsp_timeout,
  output logic [15:0]            drop_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  arb_state_e      state, state_nxt;
  logic [IDX_W-1:0] grant_nxt, pick_idx;
  logic            pick_vld;
  logic [31:0]     cmd_hold, rsp_buf, cur_cmd;
  logic [TW-1:0]   timer;
  logic            ld_cmd, ld_rsp, tmr_inc, tmo;

  cmd_arb_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req      (~req_cmd_waitreq),
    .last     (grant_id),
    .valid    (pick_vld),
    .next_idx (pick_idx)
  );

  assign cur_cmd = cmd_slice(BUS_W'(req_cmd_data), int'(grant_id));

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    ld_cmd    = 1'b0;
    ld_rsp    = 1'b0;
    tmr_inc   = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: if (pick_vld) begin
        grant_nxt = pick_idx;
        state_nxt = S_CMD;
      end
      S_CMD: if (arb_cmd_rdreq) begin
        ld_cmd    = 1'b1;
        state_nxt = S_RSP;
      end else if (req_cmd_waitreq[grant_id]) begin
        state_nxt = S_IDLE;
      end
      S_RSP: if (arb_rsp_wrreq) begin
        ld_rsp    = 1'b1;
        state_nxt = S_DLV;
      end else if (timer == TMAX) begin
        tmo       = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        tmr_inc   = 1'b1;
      end
      S_DLV: if (!req_rsp_waitreq[grant_id]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant_id    <= IDX_W'(N_REQ - 1);
      cmd_hold    <= '0;
      rsp_buf     <= '0;
      timer       <= '0;
      drop_cnt    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_nxt;
      rsp_timeout <= tmo;
      if (ld_cmd) begin
        cmd_hold <= cur_cmd;
        timer    <= '0;
      end else if (tmr_inc) begin
        timer <= timer + TW'(1);
      end
      if (ld_rsp) rsp_buf  <= arb_rsp_data;
      if (tmo)    drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  always_comb begin
    req_cmd_rdreq = '0;
    req_rsp_wrreq = '0;
    if (state == S_CMD) req_cmd_rdreq[grant_id] = arb_cmd_rdreq;
    if (state == S_DLV) req_rsp_wrreq[grant_id] = !req_rsp_waitreq[grant_id];
  end

  assign arb_cmd_data    = (state == S_CMD) ? cur_cmd : cmd_hold;
  assign arb_cmd_waitreq = (state == S_CMD) ? req_cmd_waitreq[grant_id] : 1'b1;
  assign arb_rsp_waitreq = (state != S_RSP);
  assign req_rsp_data    = rsp_buf;
  assign busy            = (state != S_IDLE);

endmodule
